// File: rtl/alu_i2c_target.sv
// alu_i2c_target: I2C target exposing {A,0}+{B,00}+Cin through a small pointer-addressed register file.
// Define ALU_I2C_GLITCH_FILTER_EN to add a 3-sample majority filter on the synchronised SCL/SDA.
module alu_i2c_target #(
    parameter logic [6:0] DEV_ADDR    = 7'h42,
    parameter int         SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       scl_in,
    input  logic       sda_in,
    output logic       sda_oe,
    output logic [7:0] sum,
    output logic [2:0] cout,
    output logic       busy
);
    typedef enum logic [3:0] {
        IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WACK, RDATA, RACK, WAIT_STOP
    } state_t;

    state_t                 state_q, state_d;
    logic [SYNC_STAGES-1:0] scl_sync_q, scl_sync_d, sda_sync_q, sda_sync_d;
    logic                   scl_p_q, scl_p_d, sda_p_q, sda_p_d;
    logic [3:0]             cnt_q, cnt_d;
    logic [6:0]             shift_q, shift_d;
    logic [2:0]             ptr_q, ptr_d;
    logic                   rw_q, rw_d;
    logic [7:0]             a_q, a_d, b_q, b_d;
    logic                   cin_q, cin_d;
    logic [7:0]             sum_q, sum_d;
    logic [2:0]             cout_q, cout_d;
    logic                   sda_oe_q, sda_oe_d, busy_q, busy_d;
    logic                   scl_s, sda_s, scl_rise, scl_fall, start, stop;
    logic [7:0]             byte_in, rd_byte;
    logic [10:0]            res;

`ifdef ALU_I2C_GLITCH_FILTER_EN
    logic [1:0] scl_h_q, scl_h_d, sda_h_q, sda_h_d;
    logic       scl_f_q, scl_f_d, sda_f_q, sda_f_d;
    logic       scl_r, sda_r;

    assign scl_r = scl_sync_q[SYNC_STAGES-1];
    assign sda_r = sda_sync_q[SYNC_STAGES-1];

    // A level must be seen in two of the last three samples to pass, so 1-clk pulses vanish.
    always_comb begin
        scl_h_d = {scl_h_q[0], scl_r};
        sda_h_d = {sda_h_q[0], sda_r};
        scl_f_d = (scl_r & scl_h_q[0]) | (scl_r & scl_h_q[1]) | (scl_h_q[0] & scl_h_q[1]);
        sda_f_d = (sda_r & sda_h_q[0]) | (sda_r & sda_h_q[1]) | (sda_h_q[0] & sda_h_q[1]);
    end

    always_ff @(posedge clk)
        if (reset) begin
            scl_h_q <= '1;
            sda_h_q <= '1;
            scl_f_q <= 1'b1;
            sda_f_q <= 1'b1;
        end else begin
            scl_h_q <= scl_h_d;
            sda_h_q <= sda_h_d;
            scl_f_q <= scl_f_d;
            sda_f_q <= sda_f_d;
        end

    assign scl_s = scl_f_q;
    assign sda_s = sda_f_q;
`else
    assign scl_s = scl_sync_q[SYNC_STAGES-1];
    assign sda_s = sda_sync_q[SYNC_STAGES-1];
`endif

    assign scl_rise = scl_s & ~scl_p_q;
    assign scl_fall = ~scl_s & scl_p_q;
    assign start    = scl_s & scl_p_q & sda_p_q & ~sda_s;
    assign stop     = scl_s & scl_p_q & ~sda_p_q & sda_s;

    always_comb begin
        scl_sync_d = {scl_sync_q[SYNC_STAGES-2:0], scl_in};
        sda_sync_d = {sda_sync_q[SYNC_STAGES-2:0], sda_in};
        scl_p_d    = scl_s;
        sda_p_d    = sda_s;
        byte_in    = {shift_q, sda_s};
        rd_byte    = ptr_q == 3'd0 ? a_q :
                     ptr_q == 3'd1 ? b_q :
                     ptr_q == 3'd2 ? {7'd0, cin_q} :
                     ptr_q == 3'd3 ? sum_q :
                     ptr_q == 3'd4 ? {5'd0, cout_q} : 8'h00;
        state_d    = state_q;
        cnt_d      = cnt_q;
        shift_d    = shift_q;
        ptr_d      = ptr_q;
        rw_d       = rw_q;
        a_d        = a_q;
        b_d        = b_q;
        cin_d      = cin_q;
        sda_oe_d   = sda_oe_q;
        busy_d     = busy_q;
        if (stop) begin
            state_d  = IDLE;
            busy_d   = 1'b0;
            sda_oe_d = 1'b0;
        end else if (start) begin
            state_d  = ADDR;
            cnt_d    = 4'd0;
            sda_oe_d = 1'b0;
        end else if (scl_rise) begin
            case (state_q)
                ADDR, PTR, WDATA: begin
                    shift_d = byte_in[6:0];
                    cnt_d   = cnt_q + 4'd1;
                    if (cnt_q == 4'd7) begin
                        cnt_d = 4'd0;
                        if (state_q == ADDR) begin
                            state_d = byte_in[7:1] == DEV_ADDR ? ADDR_ACK : WAIT_STOP;
                            busy_d  = byte_in[7:1] == DEV_ADDR;
                            rw_d    = byte_in[0];
                        end else if (state_q == PTR) begin
                            state_d = PTR_ACK;
                            ptr_d   = byte_in[2:0];
                        end else begin
                            state_d = WACK;
                            ptr_d   = ptr_q + 3'd1;
                            a_d     = ptr_q == 3'd0 ? byte_in : a_q;
                            b_d     = ptr_q == 3'd1 ? byte_in : b_q;
                            cin_d   = ptr_q == 3'd2 ? byte_in[0] : cin_q;
                        end
                    end
                end
                RDATA: begin
                    cnt_d = cnt_q + 4'd1;
                    ptr_d = cnt_q == 4'd7 ? ptr_q + 3'd1 : ptr_q;
                end
                RACK: begin
                    state_d = sda_s ? WAIT_STOP : RACK;
                    cnt_d   = 4'd1;
                end
                default: ;
            endcase
        end else if (scl_fall) begin
            case (state_q)
                // First fall starts the ACK pulse, second fall ends it and hands over.
                ADDR_ACK, PTR_ACK, WACK: begin
                    sda_oe_d = ~sda_oe_q;
                    if (sda_oe_q) begin
                        cnt_d   = 4'd0;
                        state_d = state_q == ADDR_ACK ? (rw_q ? RDATA : PTR) : WDATA;
                        if (state_q == ADDR_ACK && rw_q) begin
                            shift_d  = rd_byte[6:0];
                            sda_oe_d = ~rd_byte[7];
                        end
                    end
                end
                RDATA: begin
                    if (cnt_q == 4'd8) begin
                        state_d  = RACK;
                        cnt_d    = 4'd0;
                        sda_oe_d = 1'b0;
                    end else begin
                        shift_d  = {shift_q[5:0], 1'b0};
                        sda_oe_d = ~shift_q[6];
                    end
                end
                RACK: begin
                    if (cnt_q != 4'd0) begin
                        state_d  = RDATA;
                        cnt_d    = 4'd0;
                        shift_d  = rd_byte[6:0];
                        sda_oe_d = ~rd_byte[7];
                    end
                end
                default: ;
            endcase
        end
        // Built from the next operand values so a write and the result land together.
        res    = {2'b00, a_d, 1'b0} + {1'b0, b_d, 2'b00} + {10'd0, cin_d};
        sum_d  = res[7:0];
        cout_d = res[10:8];
    end

    always_ff @(posedge clk)
        if (reset) begin
            state_q    <= IDLE;
            scl_sync_q <= '1;
            sda_sync_q <= '1;
            scl_p_q    <= 1'b1;
            sda_p_q    <= 1'b1;
            cnt_q      <= 4'd0;
            shift_q    <= 7'd0;
            ptr_q      <= 3'd0;
            rw_q       <= 1'b0;
            a_q        <= 8'd0;
            b_q        <= 8'd0;
            cin_q      <= 1'b0;
            sum_q      <= 8'd0;
            cout_q     <= 3'd0;
            sda_oe_q   <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            scl_sync_q <= scl_sync_d;
            sda_sync_q <= sda_sync_d;
            scl_p_q    <= scl_p_d;
            sda_p_q    <= sda_p_d;
            cnt_q      <= cnt_d;
            shift_q    <= shift_d;
            ptr_q      <= ptr_d;
            rw_q       <= rw_d;
            a_q        <= a_d;
            b_q        <= b_d;
            cin_q      <= cin_d;
            sum_q      <= sum_d;
            cout_q     <= cout_d;
            sda_oe_q   <= sda_oe_d;
            busy_q     <= busy_d;
        end

    assign sda_oe = sda_oe_q;
    assign sum    = sum_q;
    assign cout   = cout_q;
    assign busy   = busy_q;
endmodule

// File: tb/tb_alu_i2c_target.sv
// tb_alu_i2c_target: bit-banged I2C controller driving alu_i2c_target, checked against a register-file model.
module tb_alu_i2c_target;
    localparam int H = 10;

    logic       clk = 1'b0, reset = 1'b1, scl_c = 1'b1, sda_c = 1'b1, g_hi = 1'b0;
    logic       sda_oe, busy;
    logic [7:0] sum;
    logic [2:0] cout;
    wire        sda_line = (sda_c | g_hi) & ~sda_oe;

    int         n_cmp = 0, n_bad = 0;
    logic [7:0] m_a = 8'd0, m_b = 8'd0;
    logic       m_cin = 1'b0, m_busy = 1'b0, m_sel = 1'b0;
    logic [2:0] m_ptr = 3'd0;
    bit         no_drive = 1'b0;
    time        quiet_until = 0;
    logic [7:0] wbuf [4];
    logic [7:0] rbuf [4];

    alu_i2c_target dut (
        .clk(clk), .reset(reset), .scl_in(scl_c), .sda_in(sda_line),
        .sda_oe(sda_oe), .sum(sum), .cout(cout), .busy(busy)
    );

    always #5 clk = ~clk;

    function automatic int m_res();
        return 2 * int'(m_a) + 4 * int'(m_b) + int'(m_cin);
    endfunction

    function automatic logic [7:0] m_rd(input logic [2:0] p);
        case (p)
            3'd0: return m_a;
            3'd1: return m_b;
            3'd2: return {7'd0, m_cin};
            3'd3: return 8'(m_res() % 256);
            3'd4: return 8'(m_res() / 256);
            default: return 8'h00;
        endcase
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic wt(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic mark();
        quiet_until = $time + 14 * 10;
    endtask

    // Model reaction to a complete byte, applied at its 8th SCL rise.
    task automatic m_rx(input logic [7:0] b, input int kind);
        mark();
        if (kind == 0) begin
            m_sel  = b[7:1] == 7'h42;
            m_busy = m_sel;
        end else if (kind == 1) begin
            if (m_sel) m_ptr = b[2:0];
        end else if (m_sel) begin
            if (m_ptr == 3'd0) m_a = b;
            else if (m_ptr == 3'd1) m_b = b;
            else if (m_ptr == 3'd2) m_cin = b[0];
            m_ptr = m_ptr + 3'd1;
        end
    endtask

    task automatic start_c();
        sda_c = 1'b1; wt(H / 2); scl_c = 1'b1; wt(H);
        sda_c = 1'b0; wt(H); scl_c = 1'b0; wt(H / 2);
    endtask

    task automatic stop_c();
        sda_c = 1'b0; wt(H / 2); scl_c = 1'b1; wt(H);
        sda_c = 1'b1; mark(); m_busy = 1'b0; m_sel = 1'b0; wt(H);
    endtask

    task automatic put_bit(input logic b);
        sda_c = b; wt(H / 2); scl_c = 1'b1; wt(H); scl_c = 1'b0; wt(H / 2);
    endtask

    task automatic send_byte(input logic [7:0] b, input int kind, output logic ack);
        for (int i = 7; i >= 0; i--) begin
            sda_c = b[i]; wt(H / 2); scl_c = 1'b1;
            if (i == 0) m_rx(b, kind);
            wt(H); scl_c = 1'b0; wt(H / 2);
        end
        sda_c = 1'b1; wt(H / 2); scl_c = 1'b1; wt(H / 2);
        ack = ~sda_line;
        wt(H / 2); scl_c = 1'b0; wt(H / 2);
    endtask

    task automatic read_byte(output logic [7:0] d, input logic ack);
        sda_c = 1'b1;
        for (int i = 7; i >= 0; i--) begin
            wt(H / 2); scl_c = 1'b1; wt(H / 2);
            d[i] = sda_line;
            wt(H / 2); scl_c = 1'b0; wt(H / 2);
        end
        sda_c = ~ack; wt(H / 2); scl_c = 1'b1; wt(H); scl_c = 1'b0; wt(H / 2);
        sda_c = 1'b1;
    endtask

    task automatic do_write(input logic [6:0] adr, input logic [7:0] p, input int n);
        logic ack;
        start_c();
        send_byte({adr, 1'b0}, 0, ack);
        chk("addr_ack", 32'(ack), 32'(adr == 7'h42));
        send_byte(p, 1, ack);
        chk("ptr_ack", 32'(ack), 32'(m_sel));
        for (int k = 0; k < n; k++) begin
            send_byte(wbuf[k], 2, ack);
            chk("data_ack", 32'(ack), 32'(m_sel));
        end
    endtask

    task automatic do_read(input logic [6:0] adr, input int n);
        logic ack;
        logic [7:0] d, e;
        start_c();
        send_byte({adr, 1'b1}, 0, ack);
        chk("raddr_ack", 32'(ack), 32'(adr == 7'h42));
        for (int k = 0; k < n; k++) begin
            read_byte(d, k < n - 1);
            e = m_sel ? m_rd(m_ptr) : 8'hff;
            chk("rdata", 32'(d), 32'(e));
            rbuf[k] = d;
            if (m_sel) m_ptr = m_ptr + 3'd1;
        end
    endtask

    task automatic rst_pulse(input string nm);
        mark();
        m_a = 8'd0; m_b = 8'd0; m_cin = 1'b0; m_ptr = 3'd0; m_busy = 1'b0; m_sel = 1'b0;
        reset = 1'b1;
        wt(1);
        chk({nm, "_oe"}, 32'(sda_oe), 0);
        chk({nm, "_sum"}, 32'(sum), 0);
        chk({nm, "_cout"}, 32'(cout), 0);
        chk({nm, "_busy"}, 32'(busy), 0);
        reset = 1'b0;
    endtask

    initial begin
        logic ack;
        fork
            forever begin
                @(negedge clk);
                if (!reset && $time > quiet_until) begin
                    chk("sum", 32'(sum), 32'(m_res() % 256));
                    chk("cout", 32'(cout), 32'(m_res() / 256));
                    chk("busy", 32'(busy), 32'(m_busy));
                end
                if (no_drive) chk("no_drive_sda", 32'(sda_oe), 0);
            end
        join_none

        wt(4);
        chk("rst_oe", 32'(sda_oe), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_sum", 32'(sum), 0);
        chk("rst_cout", 32'(cout), 0);
        reset = 1'b0;
        wt(4);

        wbuf = '{8'h7f, 8'hff, 8'h01, 8'h00};
        do_write(7'h42, 8'h00, 3);
        stop_c();
        chk("t1_sum", 32'(sum), 32'h fb);
        chk("t1_cout", 32'(cout), 32'h4);

        wbuf = '{8'hff, 8'hff, 8'h01, 8'h00};
        do_write(7'h42, 8'h00, 3);
        do_write(7'h42, 8'h03, 0);
        do_read(7'h42, 2);
        chk("t2_sum_rd", 32'(rbuf[0]), 32'h fb);
        chk("t2_cout_rd", 32'(rbuf[1]), 32'h05);
        chk("t2_busy_wait", 32'(busy), 1);
        stop_c();
        chk("t2_busy_stop", 32'(busy), 0);

        no_drive = 1'b1;
        wbuf = '{8'h12, 8'h34, 8'h56, 8'h78};
        do_write(7'h43, 8'h00, 2);
        chk("t3_busy", 32'(busy), 0);
        stop_c();
        no_drive = 1'b0;

        wbuf = '{8'h3c, 8'h00, 8'h00, 8'h00};
        do_write(7'h42, 8'h01, 1);
        stop_c();
        do_write(7'h42, 8'h06, 0);
        do_read(7'h42, 3);
        stop_c();
        chk("t4_r6", 32'(rbuf[0]), 0);
        chk("t4_r7", 32'(rbuf[1]), 0);
        chk("t4_wrap", 32'(rbuf[2]), 32'h ff);
        do_read(7'h42, 1);
        stop_c();
        chk("t4_ptr_end", 32'(rbuf[0]), 32'h3c);

        // Reset in the middle of a data byte.
        start_c();
        send_byte(8'h84, 0, ack);
        send_byte(8'h00, 1, ack);
        put_bit(1'b1); put_bit(1'b1); put_bit(1'b1);
        sda_c = 1'b1; wt(H / 2); scl_c = 1'b1; wt(H / 2);
        rst_pulse("t5");
        wt(H / 2); scl_c = 1'b0; wt(H / 2);
        stop_c();
        wbuf = '{8'h11, 8'h00, 8'h00, 8'h00};
        do_write(7'h42, 8'h00, 1);
        stop_c();
        chk("t5_after_sum", 32'(sum), 32'h22);

        // Reset while the address ACK is being driven.
        start_c();
        for (int i = 7; i >= 1; i--) put_bit(i == 7 || i == 2);
        mark(); m_busy = 1'b1;
        put_bit(1'b0);
        sda_c = 1'b1; wt(H / 2); scl_c = 1'b1; wt(H / 2);
        chk("ack_drive", 32'(sda_oe), 1);
        rst_pulse("t5b");
        wt(H / 2); scl_c = 1'b0; wt(H / 2);
        stop_c();

        // One-clk SDA high pulse while SCL is high inside a transfer.
        start_c();
        send_byte(8'h84, 0, ack);
        chk("g_addr_ack", 32'(ack), 1);
        sda_c = 1'b0; wt(H / 2); scl_c = 1'b1; wt(H / 2);
        g_hi = 1'b1; wt(1); g_hi = 1'b0;
        mark();
`ifndef ALU_I2C_GLITCH_FILTER_EN
        m_busy = 1'b0;
`endif
        wt(H / 2); scl_c = 1'b0; wt(H / 2);
        chk("glitch_busy", 32'(busy), 32'(m_busy));
        stop_c();

        for (int it = 0; it < 20; it++) begin
            int op, n;
            logic [7:0] p;
            op = $urandom_range(0, 3);
            n  = $urandom_range(1, 3);
            p  = 8'($urandom);
            foreach (wbuf[k]) wbuf[k] = 8'($urandom);
            case (op)
                0: begin do_write(7'h42, p, n); stop_c(); end
                1: begin do_read(7'h42, n); stop_c(); end
                2: begin do_write(7'h42, p, 0); do_read(7'h42, n); stop_c(); end
                default: begin
                    no_drive = 1'b1;
                    do_write(7'h42 ^ 7'(1 << $urandom_range(0, 6)), p, n);
                    stop_c();
                    no_drive = 1'b0;
                end
            endcase
        end
        wt(20);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
